// File: rtl/acc_drain_pkg.sv
// acc_drain_writer shared types and constants.
// Optional build macro: ACC_DRAIN_RELU_EN (clamp negative halves to zero).
package acc_drain_pkg;

  localparam int WORD_W        = 64;
  localparam int HALF_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int NUM_WORDS_DEF = 3136;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [WORD_W-1:0] relu64(
    input logic [WORD_W-1:0] d
  );
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
    hi = d[WORD_W-1] ? '0 : d[WORD_W-1:HALF_W];
    lo = d[HALF_W-1] ? '0 : d[HALF_W-1:0];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/acc_sync_fifo.sv
// Small synchronous FIFO with head read straight from the
// storage registers (no fall-through bypass).
module acc_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  // storage is cleared so the write data bus reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/acc_drain_writer.sv
// Drains accumulator results through a FIFO onto a req/ack write bus.
// Optional build macro: ACC_DRAIN_RELU_EN (clamp negative halves).
module acc_drain_writer
  import acc_drain_pkg::*;
#(
  parameter int                NUM_WORDS = NUM_WORDS_DEF,
  parameter int                DEPTH     = 8,
  parameter int                SKID      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              conv_done,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              bus_free,
  output logic              output_done,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic              bus_ack,
  output logic              ovf_err
);

  localparam int             CW   = $clog2(NUM_WORDS + 1);
  localparam int             FW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(NUM_WORDS);

  state_t            state;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     rcv_cnt;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     issue_nxt;
  logic [CW-1:0]     rcv_nxt;
  logic [FW-1:0]     fcnt;
  logic [FW-1:0]     fcnt_nxt;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] din;
  logic [WORD_W-1:0] head;

`ifdef ACC_DRAIN_RELU_EN
  assign din = relu64(data_i);
`else
  assign din = data_i;
`endif

  assign accept    = valid_i && (state == DRAIN) && (rcv_cnt != LAST);
  assign push      = accept && !full;
  assign bus_req   = !empty && ((state == DRAIN) || (state == FLUSH));
  assign pop       = bus_req && bus_ack;
  assign fcnt_nxt  = fcnt + FW'(push) - FW'(pop);
  assign issue_nxt = issue_cnt + CW'(bus_free && (issue_cnt != LAST));
  assign rcv_nxt   = rcv_cnt + CW'(accept);
  assign bus_wdata = head;
  assign bus_addr  = BASE_ADDR
                   + ADDR_W'(wr_cnt) * ADDR_W'(ADDR_STEP);

  acc_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (fcnt),
    .full  (full),
    .empty (empty)
  );

  // FLUSH ends on an empty FIFO so dropped words cannot stall completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      rcv_cnt     <= '0;
      wr_cnt      <= '0;
      bus_free    <= 1'b0;
      output_done <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      issue_cnt <= issue_nxt;
      rcv_cnt   <= rcv_nxt;
      if (pop) wr_cnt <= wr_cnt + 1'b1;
      if (accept && full) ovf_err <= 1'b1;
      bus_free <= (state == DRAIN) && (issue_nxt < LAST)
               && (fcnt_nxt <= FW'(DEPTH - SKID));
      unique case (state)
        IDLE:  if (conv_done) state <= DRAIN;
        DRAIN: if (rcv_nxt == LAST) state <= FLUSH;
        FLUSH: if (fcnt_nxt == '0) begin
          state       <= DONE;
          output_done <= 1'b1;
        end
        DONE:  state <= DONE;
      endcase
    end
  end

endmodule
